cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single CPU-side request/result port of the L1 cache between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Sits between the core and the L1 cache instance.
- Grants one requester at a time and holds the cache request stable until the cache reports ready.
- Routes the returned data to the owning requester as a one-cycle response pulse.

Parameters:
- ADDR_W, 27, word address width; matches the cache request addr field.
- DATA_W, 32, data width; matches the cache request and result data fields.
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = LS always wins over IF.
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- if_req_valid  in  1  IF read request.
- if_req_addr  in  ADDR_W  IF address.
- if_req_ready  out  1  IF request accepted this cycle.
- if_rsp_valid  out  1  IF response pulse.
- if_rsp_data  out  DATA_W  IF read data.
- ls_req_valid  in  1  LS request.
- ls_req_addr  in  ADDR_W  LS address.
- ls_req_wdata  in  DATA_W  LS write data.
- ls_req_rw  in  1  1 = write, 0 = read (same encoding as the cache request rw field).
- ls_req_ready  out  1  LS request accepted this cycle.
- ls_rsp_valid  out  1  LS response pulse.
- ls_rsp_data  out  DATA_W  LS read data.
- cache_req  out  cpu_req_type  {addr, data, rw, valid} to the cache.
- cache_res  in  cpu_result_type  {data, ready} from the cache.
- arb_err  out  1  sticky watchdog error; tied 0 when the watchdog is compiled out.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous):
  - state = IDLE; round-robin pointer = IF-last, so LS wins the first tie.
  - All outputs 0, including cache_req.valid, both req_ready, both rsp_valid, rsp data, arb_err.
  - Reset mid-transaction abandons the transaction; no response is issued. The cache is re-synchronised by its own reset.
- State IDLE:
  - Winner selection:
    - FIXED_PRIO = 1: LS wins whenever ls_req_valid is high.
    - FIXED_PRIO = 0: with both valid, the requester not granted last wins; with one valid, that one wins.
  - The winner's req_ready is asserted combinationally in this cycle. The request is accepted when valid and ready are both high.
  - On acceptance: latch addr, wdata, rw and owner (IF forces rw = 0 and data = 0); update the round-robin pointer; go to BUSY.
  - No request pending: stay in IDLE.
- State BUSY:
  - cache_req.valid = 1; addr, data and rw are driven from the latched registers and stay stable for the whole state.
  - cache_res.ready high: latch cache_res.data; go to RESP.
  - Both req_ready are 0.
- State RESP:
  - cache_req.valid = 0. This guarantees at least one idle cycle between cache requests.
  - The owner's rsp_valid = 1 for exactly this cycle; rsp_data = latched data.
  - For a write, rsp_data = the latched cache data, contents don't-care; the pulse marks completion.
  - Next state IDLE.
- Latency:
  - Accept at cycle t; cache_req.valid rises at t+1.
  - If cache_res.ready is sampled at t+k, rsp_valid is at t+k+1; the next accept is possible at t+k+2.
  - Minimum accept-to-response time is 2 cycles.
- Boundary conditions:
  - cache_res.ready in IDLE or RESP: ignored.
  - A requester dropping valid before acceptance: allowed, nothing is latched.
  - Requester inputs after acceptance: don't-care.
  - rsp data outputs hold their last value outside the pulse.
  - Only one transaction is outstanding at a time; there is no queueing.

Optional Feature:
- Macro: CACHE_ARB_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES, arb_err sets and stays set until reset; it is suitable for driving led_memory.
  - The FSM keeps waiting; no abort.
- Undefined: no counter logic; arb_err tied 0.

Decomposition:
- Shared cache package: cpu_req_type, cpu_result_type, ADDR_W/DATA_W constants, and the state enum arb_state_t {IDLE, BUSY, RESP}.
- Sub-module: rr_grant2, the combinational 2-way winner selection (FIXED_PRIO handling plus pointer input), reusable elsewhere.
- The FSM and latches stay in cache_port_arbiter.

Test Plan:
- Single IF read, addr 27'h0AAAAAA, cache model returns 32'h33333333 with ready 3 cycles after valid -> if_req_ready at t; cache_req.valid t+1..t+3; if_rsp_valid only at t+4 with data 32'h33333333; ls_rsp_valid stays 0.
- LS write, addr 27'h0AAAAAB, wdata 32'h1C71C71C, rw = 1 -> cache_req carries exactly those fields, stable until ready; one ls_rsp_valid pulse; then an LS read of the same addr returns 32'h1C71C71C.
- Both valid every cycle, FIXED_PRIO = 0, four transactions -> grants alternate LS, IF, LS, IF; cache_req.valid is low for at least 1 cycle between transactions.
- Same stimulus with FIXED_PRIO = 1 -> all grants to LS while ls_req_valid is high; IF granted only when LS is idle.
- rst_n pulsed low while in BUSY -> cache_req.valid drops asynchronously; no rsp_valid; the next request after reset is accepted normally.
- With CACHE_ARB_WATCHDOG_EN, TIMEOUT_CYCLES = 16, cache never ready -> arb_err rises after 16 BUSY cycles and stays high; without the macro arb_err stays 0.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter_pkg
// Shared L1-cache CPU-port types and arbiter state encoding.
//   cpu_req_type    : {addr, data, rw, valid} request into the cache
//   cpu_result_type : {data, ready} result from the cache
//   arb_state_t     : arbiter FSM states IDLE / BUSY / RESP
// ----------------------------------------------------------------------------
package cache_port_arbiter_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
        logic              valid;
    } cpu_req_type;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ready;
    } cpu_result_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_port_arbiter_rr_grant2.sv
// ----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way winner selection.
//   req[1:0]  : request lines; index 1 is the priority side in fixed mode
//   last_gnt  : index granted most recently (round-robin pointer)
//   gnt[1:0]  : one-hot grant, zero when nothing requests
// FIXED_PRIO = 1 makes req[1] win whenever it is high; FIXED_PRIO = 0 gives a
// tie to the index that was not granted last.
// ----------------------------------------------------------------------------
module rr_grant2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (FIXED_PRIO != 0) begin
            gnt[1] = req[1];
            gnt[0] = req[0] & ~req[1];
        end else if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
// Shares the single CPU-side port of the L1 cache between instruction fetch
// (IF, read-only) and the load/store unit (LS, read/write). One transaction is
// outstanding at a time; the request is held stable until the cache reports
// ready, and the result comes back to the owner as a one-cycle pulse.
//
// Ports
//   sys_clk, rst_n               clock, asynchronous active-low reset
//   if_req_valid/addr/ready      IF request handshake
//   if_rsp_valid/data            IF response pulse and held read data
//   ls_req_valid/addr/wdata/rw   LS request (rw = 1 write)
//   ls_req_ready                 LS request accepted this cycle
//   ls_rsp_valid/data            LS response pulse and held read data
//   cache_req / cache_res        cache CPU port
//   arb_err                      sticky watchdog error
//
// Optional feature: define CACHE_ARB_WATCHDOG_EN to build a 16-bit BUSY-cycle
// watchdog that sets arb_err at TIMEOUT_CYCLES; otherwise arb_err is tied 0.
// ADDR_W/DATA_W must match the package widths used by the cache structs.
// ----------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter int ADDR_W         = cache_port_arbiter_pkg::ADDR_W,
    parameter int DATA_W         = cache_port_arbiter_pkg::DATA_W,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                                   sys_clk,
    input  logic                                   rst_n,
    input  logic                                   if_req_valid,
    input  logic [ADDR_W-1:0]                      if_req_addr,
    output logic                                   if_req_ready,
    output logic                                   if_rsp_valid,
    output logic [DATA_W-1:0]                      if_rsp_data,
    input  logic                                   ls_req_valid,
    input  logic [ADDR_W-1:0]                      ls_req_addr,
    input  logic [DATA_W-1:0]                      ls_req_wdata,
    input  logic                                   ls_req_rw,
    output logic                                   ls_req_ready,
    output logic                                   ls_rsp_valid,
    output logic [DATA_W-1:0]                      ls_rsp_data,
    output cache_port_arbiter_pkg::cpu_req_type    cache_req,
    input  cache_port_arbiter_pkg::cpu_result_type cache_res,
    output logic                                   arb_err
);

    import cache_port_arbiter_pkg::*;

    arb_state_t        state_q, state_nxt;
    logic [1:0]        req_vec;
    logic [1:0]        gnt;
    logic              accept;
    logic              last_gnt_q;     // 1 = LS was granted last
    logic              owner_ls_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] ls_data_q;

    // Requests are masked during reset so both ready outputs read 0 then.
    assign req_vec = {ls_req_valid, if_req_valid} & {2{rst_n}};

    rr_grant2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_grant (
        .req      (req_vec),
        .last_gnt (last_gnt_q),
        .gnt      (gnt)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            owner_ls_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                last_gnt_q <= gnt[1];
                owner_ls_q <= gnt[1];
            end
        end
    end

    always_comb begin
        state_nxt    = state_q;
        accept       = 1'b0;
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        cache_req    = '0;
        case (state_q)
            IDLE: begin
                if_req_ready = gnt[0];
                ls_req_ready = gnt[1];
                if (gnt != 2'b00) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                cache_req.valid = 1'b1;
                cache_req.addr  = addr_q;
                cache_req.data  = data_q;
                cache_req.rw    = rw_q;
                if (cache_res.ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch: IF is always a read carrying zero data.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            if (gnt[1]) begin
                addr_q <= ls_req_addr;
                data_q <= ls_req_wdata;
                rw_q   <= ls_req_rw;
            end else begin
                addr_q <= if_req_addr;
                data_q <= '0;
                rw_q   <= 1'b0;
            end
        end
    end

    // Result latch: one register per requester so each holds its own last value.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            if_data_q <= '0;
            ls_data_q <= '0;
        end else if (state_q == BUSY && cache_res.ready) begin
            if (owner_ls_q) begin
                ls_data_q <= cache_res.data;
            end else begin
                if_data_q <= cache_res.data;
            end
        end
    end

    assign if_rsp_valid = (state_q == RESP) && !owner_ls_q;
    assign ls_rsp_valid = (state_q == RESP) &&  owner_ls_q;
    assign if_rsp_data  = if_data_q;
    assign ls_rsp_data  = ls_data_q;

`ifdef CACHE_ARB_WATCHDOG_EN
    localparam int          WDOG_W     = 16;
    localparam [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic [WDOG_W-1:0] wdog_cnt_inc;
    logic              arb_err_q;

    assign wdog_cnt_inc = wdog_cnt_q + 1'b1;

    // Counter saturates at all-ones; the error flag fires on the edge the
    // count reaches the limit and stays until reset. No abort is attempted.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                wdog_cnt_q <= '0;
            end else if (state_q == BUSY && wdog_cnt_q != '1) begin
                wdog_cnt_q <= wdog_cnt_inc;
                if (wdog_cnt_inc == WDOG_LIMIT) begin
                    arb_err_q <= 1'b1;
                end
            end
        end
    end

    assign arb_err = arb_err_q;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
`timescale 1ns/1ps
module tb_cache_port_arbiter;
    import cache_port_arbiter_pkg::*;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        rst_n;
    logic        if_req_valid;
    logic [26:0] if_req_addr;
    logic        ls_req_valid;
    logic [26:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_req_rw;

    // round-robin instance (a_) and fixed-priority instance (f_)
    logic        a_if_req_ready, a_if_rsp_valid, a_ls_req_ready, a_ls_rsp_valid, a_arb_err;
    logic [31:0] a_if_rsp_data, a_ls_rsp_data;
    cpu_req_type    a_req;
    cpu_result_type a_res;
    logic        f_if_req_ready, f_if_rsp_valid, f_ls_req_ready, f_ls_rsp_valid, f_arb_err;
    logic [31:0] f_if_rsp_data, f_ls_rsp_data;
    cpu_req_type    f_req;
    cpu_result_type f_res;

    int num_checks = 0;
    int num_errors = 0;

    cache_port_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) dut_rr (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(a_if_req_ready),
        .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_rw(ls_req_rw), .ls_req_ready(a_ls_req_ready),
        .ls_rsp_valid(a_ls_rsp_valid), .ls_rsp_data(a_ls_rsp_data),
        .cache_req(a_req), .cache_res(a_res), .arb_err(a_arb_err)
    );

    cache_port_arbiter #(.ADDR_W(27), .DATA_W(32), .FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) dut_fp (
        .sys_clk(sys_clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(f_if_req_ready),
        .if_rsp_valid(f_if_rsp_valid), .if_rsp_data(f_if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata),
        .ls_req_rw(ls_req_rw), .ls_req_ready(f_ls_req_ready),
        .ls_rsp_valid(f_ls_rsp_valid), .ls_rsp_data(f_ls_rsp_data),
        .cache_req(f_req), .cache_res(f_res), .arb_err(f_arb_err)
    );

    // Cache model for the round-robin instance: ready after ready_delay
    // valid cycles, 16-word memory indexed by addr[3:0].
    logic [31:0] mem [16];
    int ready_delay;
    bit never_ready;
    int wait_cnt;

    always_comb begin
        a_res.ready = a_req.valid && !never_ready && (wait_cnt >= ready_delay - 1);
        a_res.data  = mem[a_req.addr[3:0]];
    end

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[4'hA] <= 32'h33333333;
        end else if (!a_req.valid) begin
            wait_cnt <= 0;
        end else if (!a_res.ready) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
            if (a_req.rw) mem[a_req.addr[3:0]] <= a_req.data;
        end
    end

    // Cache model for the fixed-priority instance: always ready, data = address.
    always_comb begin
        f_res.ready = f_req.valid;
        f_res.data  = {5'b0, f_req.addr};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_tb: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic exp_ls;
        logic exp_err;
`ifdef CACHE_ARB_WATCHDOG_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b1;
        if_req_valid = 0; if_req_addr = '0;
        ls_req_valid = 0; ls_req_addr = '0; ls_req_wdata = '0; ls_req_rw = 0;
        ready_delay = 1; never_ready = 0;
        #1 rst_n = 1'b0;
        if_req_valid = 1'b1;
        #2;
        // reset state
        check("rst_cache_valid", a_req.valid, 0);
        check("rst_cache_req", a_req, 0);
        check("rst_if_ready", a_if_req_ready, 0);
        check("rst_ls_ready", a_ls_req_ready, 0);
        check("rst_rsp_valid", {a_if_rsp_valid, a_ls_rsp_valid}, 0);
        check("rst_rsp_data", {a_if_rsp_data, a_ls_rsp_data}, 0);
        check("rst_arb_err", a_arb_err, 0);
        if_req_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();

        // single IF read, ready in third BUSY cycle
        ready_delay = 3;
        if_req_valid = 1'b1; if_req_addr = 27'h0AAAAAA;
        #1;
        check("if1_ready_t", a_if_req_ready, 1);
        check("if1_ls_ready_t", a_ls_req_ready, 0);
        step();
        if_req_valid = 1'b0; if_req_addr = 27'h0;
        check("if1_valid_t1", a_req.valid, 1);
        check("if1_addr_t1", a_req.addr, 27'h0AAAAAA);
        check("if1_rw_data_t1", {a_req.rw, a_req.data}, 0);
        step();
        check("if1_valid_t2", a_req.valid, 1);
        step();
        check("if1_valid_t3", a_req.valid, 1);
        check("if1_rsp_early", a_if_rsp_valid, 0);
        step();
        check("if1_valid_t4", a_req.valid, 0);
        check("if1_rsp_valid_t4", a_if_rsp_valid, 1);
        check("if1_rsp_data_t4", a_if_rsp_data, 32'h33333333);
        check("if1_ls_rsp_t4", a_ls_rsp_valid, 0);
        step();
        check("if1_rsp_valid_t5", a_if_rsp_valid, 0);
        check("if1_rsp_hold_t5", a_if_rsp_data, 32'h33333333);

        // LS write then read-back of the same address
        ready_delay = 2;
        ls_req_valid = 1'b1; ls_req_addr = 27'h0AAAAAB; ls_req_wdata = 32'h1C71C71C; ls_req_rw = 1'b1;
        #1;
        check("lsw_ready", a_ls_req_ready, 1);
        check("lsw_if_ready", a_if_req_ready, 0);
        step();
        ls_req_valid = 1'b0; ls_req_addr = 27'h0; ls_req_wdata = 32'hFFFFFFFF; ls_req_rw = 1'b0;
        check("lsw_req_t1", a_req, {27'h0AAAAAB, 32'h1C71C71C, 1'b1, 1'b1});
        check("lsw_ready_busy", {a_if_req_ready, a_ls_req_ready}, 0);
        step();
        check("lsw_req_t2", a_req, {27'h0AAAAAB, 32'h1C71C71C, 1'b1, 1'b1});
        step();
        check("lsw_rsp_pulse", {a_ls_rsp_valid, a_if_rsp_valid, a_req.valid}, 3'b100);
        step();
        check("lsw_rsp_end", a_ls_rsp_valid, 0);
        ls_req_valid = 1'b1; ls_req_addr = 27'h0AAAAAB; ls_req_wdata = 32'h0; ls_req_rw = 1'b0;
        #1;
        check("lsr_ready", a_ls_req_ready, 1);
        step();
        ls_req_valid = 1'b0;
        check("lsr_req_t1", {a_req.addr, a_req.rw, a_req.valid}, {27'h0AAAAAB, 1'b0, 1'b1});
        step();
        step();
        check("lsr_rsp_valid", a_ls_rsp_valid, 1);
        check("lsr_rsp_data", a_ls_rsp_data, 32'h1C71C71C);
        check("lsr_if_data_hold", a_if_rsp_data, 32'h33333333);
        step();

        // reset while BUSY
        ready_delay = 10;
        if_req_valid = 1'b1; if_req_addr = 27'h0AAAAAA;
        step();
        if_req_valid = 1'b0;
        check("rstb_busy", a_req.valid, 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rstb_async_valid", a_req.valid, 0);
        check("rstb_rsp", {a_if_rsp_valid, a_ls_rsp_valid}, 0);
        check("rstb_if_data", a_if_rsp_data, 0);
        step();
        check("rstb_rsp_later", {a_if_rsp_valid, a_ls_rsp_valid}, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rstb_no_rsp", {a_if_rsp_valid, a_ls_rsp_valid, a_req.valid}, 0);

        // both requesting every cycle: RR alternates LS,IF,...; fixed always LS
        ready_delay = 1;
        if_req_valid = 1'b1; if_req_addr = 27'h0AAAAAA;
        ls_req_valid = 1'b1; ls_req_addr = 27'h0AAAAAB; ls_req_wdata = 32'h0; ls_req_rw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_ls = ((i % 2) == 0);
            #1;
            check("rr_grant", {a_ls_req_ready, a_if_req_ready}, {exp_ls, !exp_ls});
            check("fp_grant", {f_ls_req_ready, f_if_req_ready}, 2'b10);
            step();
            check("rr_busy_addr", {a_req.valid, a_req.addr}, {1'b1, exp_ls ? 27'h0AAAAAB : 27'h0AAAAAA});
            check("fp_busy_addr", {f_req.valid, f_req.addr}, {1'b1, 27'h0AAAAAB});
            step();
            check("rr_rsp_owner", {a_req.valid, a_ls_rsp_valid, a_if_rsp_valid}, {1'b0, exp_ls, !exp_ls});
            check("fp_rsp_owner", {f_ls_rsp_valid, f_if_rsp_valid}, 2'b10);
            step();
            check("rr_gap_idle", a_req.valid, 0);
        end
        check("fp_ls_data", f_ls_rsp_data, 32'h0AAAAAB);

        // LS idle: fixed-priority instance now serves IF
        ls_req_valid = 1'b0;
        #1;
        check("fp_if_grant", {f_ls_req_ready, f_if_req_ready}, 2'b01);
        step();
        if_req_valid = 1'b0;
        step();
        check("fp_if_rsp", f_if_rsp_valid, 1);
        check("fp_if_data", f_if_rsp_data, 32'h0AAAAAA);
        step();

        // watchdog: cache never ready
        never_ready = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 27'h0AAAAAA;
        step();
        if_req_valid = 1'b0;
        for (int k = 1; k < 16; k++) step();
        check("wdog_before_limit", a_arb_err, 0);
        check("wdog_busy_held", a_req.valid, 1);
        step();
        check("wdog_at_limit", a_arb_err, exp_err);
        step(); step(); step();
        check("wdog_sticky", a_arb_err, exp_err);
        never_ready = 1'b0;
        step();
        check("wdog_rsp_after", a_if_rsp_valid, 1);
        step();
        check("wdog_sticky_idle", a_arb_err, exp_err);
        check("fp_no_err", f_arb_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
